tone_sequencer: RTL and testbench

Parametrised multi-voice square-wave note sequencer. It walks a synchronous note ROM one entry per beat and generates one square tone per voice from each entry's half-period field. It mixes the voices with saturation and hands a signed sample to the audio-output path on request. It sits between the note ROM and the audio controller's left/right inputs, adding rests, per-voice enable, looping, start/stop and a working reset.

---
 rtl/tone_seq_pkg.sv | 36 +++
 rtl/tone_sequencer_voice.sv | 49 ++++
 rtl/tone_sequencer.sv | 128 ++++++++++++
 tb/tb_tone_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types, default sizing and mixing helpers for the tone sequencer.
package tone_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  localparam int DEF_VOICES     = 2;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_HALF_W     = 19;
  localparam int DEF_LAST_ADDR  = 140;
  localparam int DEF_BEAT_TICKS = 9500000;
  localparam int DEF_AMP        = 10000000;
  localparam int DEF_SAMPLE_W   = 32;

  // Headroom so the voice sum cannot wrap before saturation.
  function automatic int mix_w(input int sample_w, input int voices);
    return sample_w + $clog2(voices);
  endfunction

  // Clamp x to the signed range of a w-bit sample (w <= 63).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/tone_sequencer_voice.sv
// One square-wave voice: each level lasts half+1 run cycles; half==0 is a rest.
module square_voice
  import tone_seq_pkg::*;
#(
  parameter int HALF_W = DEF_HALF_W,
  parameter int MIX_W  = DEF_SAMPLE_W + 1,
  parameter int AMP    = DEF_AMP
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [HALF_W-1:0]       i_half,
  input  logic                    i_load,
  input  logic                    i_run,
  input  logic                    i_en,
  output logic signed [MIX_W-1:0] o_contrib
);

  localparam logic signed [MIX_W-1:0] P_AMP = MIX_W'(AMP);

  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_cnt;
  logic              r_level;
  logic              w_rest;

  assign w_rest = (r_half == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_half  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_load) begin
      r_half  <= i_half;
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (i_run && !w_rest) begin
      if (r_cnt == r_half) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The counter keeps running while muted so re-enabling stays in phase.
  assign o_contrib = (i_run && i_en && !w_rest) ? (r_level ? P_AMP : -P_AMP) : '0;

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice note sequencer: walks the note ROM one entry per beat and mixes square voices.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int VOICES     = DEF_VOICES,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int HALF_W     = DEF_HALF_W,
  parameter int LAST_ADDR  = DEF_LAST_ADDR,
  parameter int BEAT_TICKS = DEF_BEAT_TICKS,
  parameter int AMP        = DEF_AMP,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [VOICES-1:0]        voice_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [VOICES*HALF_W-1:0] rom_q,
  input  logic                     sample_req,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     sample_valid,
  output logic                     playing,
  output logic                     done
);

  localparam int MIX_W = mix_w(SAMPLE_W, VOICES);
  localparam int BT_W  = $clog2(BEAT_TICKS + 1);

  state_t                         r_state, w_state_nx;
  logic [ADDR_W-1:0]              r_addr, w_addr_nx;
  logic [BT_W-1:0]                r_beat;
  logic                           w_beat_end;
  logic [VOICES-1:0][MIX_W-1:0]   w_contrib;
  logic signed [MIX_W-1:0]        w_sum;
  logic signed [63:0]             w_sat;
  logic [SAMPLE_W-1:0]            r_sample;
  logic                           r_valid;

  assign w_beat_end = (r_beat == BT_W'(BEAT_TICKS - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    if (stop) begin
      w_state_nx = S_IDLE;
      w_addr_nx  = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          w_state_nx = S_FETCH;
          w_addr_nx  = '0;
        end
        S_FETCH: w_state_nx = S_LOAD;
        S_LOAD:  w_state_nx = S_PLAY;
        S_PLAY: if (w_beat_end) begin
          if (r_addr < ADDR_W'(LAST_ADDR)) begin
            w_addr_nx  = r_addr + 1'b1;
            w_state_nx = S_FETCH;
          end else if (loop_en) begin
            w_addr_nx  = '0;
            w_state_nx = S_FETCH;
          end else begin
            w_state_nx = S_DONE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                r_beat <= '0;
    else if (r_state == S_LOAD) r_beat <= '0;
    else if (r_state == S_PLAY) r_beat <= r_beat + 1'b1;
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    square_voice #(
      .HALF_W (HALF_W),
      .MIX_W  (MIX_W),
      .AMP    (AMP)
    ) u_voice (
      .i_clk     (CLOCK_50),
      .i_rst_n   (resetn),
      .i_half    (rom_q[v*HALF_W +: HALF_W]),
      .i_load    (r_state == S_LOAD),
      .i_run     (r_state == S_PLAY),
      .i_en      (voice_en[v]),
      .o_contrib (w_contrib[v])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int v = 0; v < VOICES; v++) w_sum = w_sum + $signed(w_contrib[v]);
  end

  assign w_sat = saturate(64'(w_sum), SAMPLE_W);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (sample_req) r_sample <= w_sat[SAMPLE_W-1:0];
      r_valid <= sample_req;
    end
  end

  assign rom_addr     = r_addr;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign playing      = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_PLAY);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized bench for tone_sequencer: two instances (normal and saturating amplitude) against a timeline model.
module tb_tone_sequencer;

  localparam int NE = 4;   // ROM entries 0..LAST_ADDR
  localparam int EP = 18;  // cycles per entry: FETCH + LOAD + 16 PLAY

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, sample_req = 1'b0;
  logic [1:0]  voice_en = 2'b00;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] q_a = '0, q_b = '0;
  logic [15:0] out_a, out_b;
  logic        val_a, val_b, play_a, play_b, done_a, done_b;

  int rom_a [NE][2];
  int rom_b [NE][2];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_a = '0, exp_b = '0;

  always #5 clk = ~clk;

  tone_sequencer #(.VOICES(2), .ADDR_W(4), .HALF_W(8), .LAST_ADDR(3), .BEAT_TICKS(16),
                   .AMP(1000), .SAMPLE_W(16)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
    .voice_en(voice_en), .rom_addr(addr_a), .rom_q(q_a), .sample_req(sample_req),
    .sample_out(out_a), .sample_valid(val_a), .playing(play_a), .done(done_a));

  tone_sequencer #(.VOICES(2), .ADDR_W(4), .HALF_W(8), .LAST_ADDR(3), .BEAT_TICKS(16),
                   .AMP(20000), .SAMPLE_W(16)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
    .voice_en(voice_en), .rom_addr(addr_b), .rom_q(q_b), .sample_req(sample_req),
    .sample_out(out_b), .sample_valid(val_b), .playing(play_b), .done(done_b));

  // Synchronous ROMs, one cycle of latency.
  always @(posedge clk) begin
    if (addr_a < 4'(NE)) q_a <= {8'(rom_a[addr_a][1]), 8'(rom_a[addr_a][0])};
    if (addr_b < 4'(NE)) q_b <= {8'(rom_b[addr_b][1]), 8'(rom_b[addr_b][0])};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle n counts from 1 = the cycle right after the start edge.
  function automatic int model_mix(input int n, input bit lp, input bit sat);
    int e, p, k, s, h, amp;
    e = (n - 1) / EP;
    p = (n - 1) % EP;
    if (!lp && e >= NE) return 0;
    if (p < 2) return 0;
    k = p - 2;
    e = e % NE;
    amp = sat ? 20000 : 1000;
    s = 0;
    for (int v = 0; v < 2; v++) begin
      h = sat ? rom_b[e][v] : rom_a[e][v];
      if (voice_en[v] && h != 0) s += (((k / (h + 1)) % 2) == 0) ? amp : -amp;
    end
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int model_addr(input int n, input bit lp);
    int e;
    e = (n - 1) / EP;
    if (!lp && e >= NE) return NE - 1;
    return e % NE;
  endfunction

  task automatic check_outputs(input string tag, input int addr, input bit pl, input bit dn, input bit vld);
    chk({tag, "_addr_a"}, 32'(addr_a), 32'(addr));
    chk({tag, "_addr_b"}, 32'(addr_b), 32'(addr));
    chk({tag, "_playing"}, 32'(play_a), 32'(pl));
    chk({tag, "_done"}, 32'(done_a), 32'(dn));
    chk({tag, "_done_b"}, 32'(done_b), 32'(dn));
    chk({tag, "_valid_a"}, 32'(val_a), 32'(vld));
    chk({tag, "_valid_b"}, 32'(val_b), 32'(vld));
    chk({tag, "_sample_a"}, 32'(out_a), 32'(exp_a));
    chk({tag, "_sample_b"}, 32'(out_b), 32'(exp_b));
  endtask

  // Start playback and follow it for ncyc cycles with random sample requests.
  // ign_at: pulse start mid-playback (must be ignored); stop_at: stop+start race ends the run.
  task automatic run_play(input int ncyc, input bit lp, input int ign_at, input int stop_at);
    bit prev;
    bit req;
    bit pl;
    loop_en = lp;
    start = 1'b1;
    sample_req = 1'b0;
    prev = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      pl = lp || ((n - 1) / EP < NE);
      check_outputs("play", model_addr(n, lp), pl, !pl, prev);
      if (n == stop_at) begin
        stop = 1'b1;
        start = 1'b1;
        sample_req = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        check_outputs("stop", 0, 1'b0, 1'b0, 1'b0);
        return;
      end
      start = (n == ign_at);
      req = 1'($urandom_range(0, 1));
      sample_req = req;
      if (req) begin
        exp_a = 16'(model_mix(n, lp, 1'b0));
        exp_b = 16'(model_mix(n, lp, 1'b1));
      end
      prev = req;
      @(negedge clk);
    end
    start = 1'b0;
    sample_req = 1'b0;
    @(negedge clk);
    chk("tail_valid", 32'(val_a), 32'(prev));
    chk("tail_sample", 32'(out_a), 32'(exp_a));
  endtask

  task automatic fill_rom_a(input int maxh);
    for (int e = 0; e < NE; e++)
      for (int v = 0; v < 2; v++) rom_a[e][v] = int'($urandom_range(0, maxh));
  endtask

  initial begin
    for (int e = 0; e < NE; e++) begin
      rom_b[e][0] = 4;
      rom_b[e][1] = 4;
    end
    fill_rom_a(6);

    // Reset state.
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    check_outputs("idle", 0, 1'b0, 1'b0, 1'b0);

    // Single voice half=3 in entry 0, voice1 rest; start pulsed mid-play in entry 1.
    rom_a[0][0] = 3;
    rom_a[0][1] = 0;
    voice_en = 2'b01;
    run_play(80, 1'b0, 25, 0);

    // Both voices enabled, random notes; dut_b saturates at +-32767/-32768.
    fill_rom_a(6);
    rom_a[1][0] = 4;
    rom_a[1][1] = 4;
    rom_a[2][0] = 0;
    rom_a[2][1] = 0;
    voice_en = 2'b11;
    run_play(80, 1'b0, 0, 0);

    // Voice1 only, looping past the last entry, then a stop/start race in PLAY.
    fill_rom_a(7);
    voice_en = 2'b10;
    run_play(100, 1'b1, 0, 95);

    // Asynchronous reset between edges in the middle of entry 1.
    fill_rom_a(5);
    voice_en = 2'($urandom_range(0, 3));
    run_play(30, 1'b0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    exp_a = '0;
    exp_b = '0;
    check_outputs("async_rst", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Playback resumes from address 0.
    fill_rom_a(6);
    voice_en = 2'b11;
    run_play(40, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
